// File: rtl/clock_ctrl_pkg.sv
// Shared types and default timing constants for the clock-setting controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam int DEFAULT_CLK_HZ          = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and command/blink outputs between the controller (master) and the time datapath (slave).
interface clock_set_ctrl_if;
    import clock_ctrl_pkg::*;

    logic  btn_mode_n;
    logic  btn_inc_n;
    mode_t mode;
    logic  sec_tick;
    logic  sec_clear;
    logic  hour_inc;
    logic  min_inc;
    logic  blank_hour;
    logic  blank_min;

    modport master (
        input  btn_mode_n, btn_inc_n,
        output mode, sec_tick, sec_clear, hour_inc, min_inc, blank_hour, blank_min
    );

    modport slave (
        output btn_mode_n, btn_inc_n,
        input  mode, sec_tick, sec_clear, hour_inc, min_inc, blank_hour, blank_min
    );

endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low button; emits a one-cycle press pulse.
module debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample matching the accepted level restarts the stability count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM, seconds prescaler and digit-blink generator for a two-button clock-setting UI.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = DEFAULT_CLK_HZ,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    clock_set_ctrl_if.master  bus
);

    localparam int                  HALF       = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int                  PRESC_W    = cnt_width(CLK_HZ);
    localparam int                  BLINK_W    = cnt_width(HALF);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(HALF - 1);

    logic [1:0] btn_n;
    logic [1:0] evt;
    logic       mode_evt;
    logic       inc_evt;

    assign btn_n = {bus.btn_inc_n, bus.btn_mode_n};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .btn_n    (btn_n[gi]),
                .press    (evt[gi])
            );
        end
    endgenerate

    assign mode_evt = evt[0];
    assign inc_evt  = evt[1];

    mode_t                state_reg, state_next;
    logic [PRESC_W-1:0]   presc_reg, presc_next;
    logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic                 phase_reg, phase_next;
    logic                 sec_tick_reg, sec_tick_next;
    logic                 sec_clear_reg, sec_clear_next;
    logic                 hour_inc_reg, hour_inc_next;
    logic                 min_inc_reg, min_inc_next;
    logic                 blank_hour_reg, blank_hour_next;
    logic                 blank_min_reg, blank_min_next;

    always_comb begin
        state_next      = state_reg;
        presc_next      = '0;
        blink_cnt_next  = '0;
        phase_next      = 1'b0;
        sec_tick_next   = 1'b0;
        sec_clear_next  = 1'b0;
        hour_inc_next   = 1'b0;
        min_inc_next    = 1'b0;

        // A mode event always wins over a simultaneous inc event.
        case (state_reg)
            RUN: begin
                if (mode_evt) begin
                    state_next     = SET_HOUR;
                    sec_clear_next = 1'b1;
                end
            end
            SET_HOUR: begin
                if (mode_evt)     state_next    = SET_MIN;
                else if (inc_evt) hour_inc_next = 1'b1;
            end
            SET_MIN: begin
                if (mode_evt)     state_next   = RUN;
                else if (inc_evt) min_inc_next = 1'b1;
            end
            default: state_next = RUN;
        endcase

        // Leaving RUN zeroes the prescaler so a tick never coincides with sec_clear.
        if (state_reg == RUN && !mode_evt) begin
            if (presc_reg == PRESC_LAST) begin
                sec_tick_next = 1'b1;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end

        // Edits and state changes restart the blink so the digits show at once.
        if (state_next != RUN && state_next == state_reg && !hour_inc_next && !min_inc_next) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                phase_next = ~phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
                phase_next     = phase_reg;
            end
        end

        blank_hour_next = (state_next == SET_HOUR) && phase_next;
        blank_min_next  = (state_next == SET_MIN)  && phase_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg      <= RUN;
            presc_reg      <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            sec_tick_reg   <= 1'b0;
            sec_clear_reg  <= 1'b0;
            hour_inc_reg   <= 1'b0;
            min_inc_reg    <= 1'b0;
            blank_hour_reg <= 1'b0;
            blank_min_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            sec_tick_reg   <= sec_tick_next;
            sec_clear_reg  <= sec_clear_next;
            hour_inc_reg   <= hour_inc_next;
            min_inc_reg    <= min_inc_next;
            blank_hour_reg <= blank_hour_next;
            blank_min_reg  <= blank_min_next;
        end
    end

    assign bus.mode       = state_reg;
    assign bus.sec_tick   = sec_tick_reg;
    assign bus.sec_clear  = sec_clear_reg;
    assign bus.hour_inc   = hour_inc_reg;
    assign bus.min_inc    = min_inc_reg;
    assign bus.blank_hour = blank_hour_reg;
    assign bus.blank_min  = blank_min_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench: scenario table, corner sequences and random buttons against a behavioural model.
module tb_clock_set_ctrl;
    import clock_ctrl_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int HALF   = CLK_HZ / 2;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Behavioural model state
    int   m_mode = 0;
    logic m_tick = 0, m_clr = 0, m_hi = 0, m_mi = 0, m_bh = 0, m_bm = 0;
    int   n_run = 0;
    int   e_blink = 0;
    logic lvl [2];
    logic ev [2];
    logic pipe [2][$];
    logic hist [2][$];

    // Observed pulse counters and timing bookkeeping
    int   cnt_tick = 0, cnt_clr = 0, cnt_hi = 0, cnt_mi = 0;
    int   run_entry = -1, run_gap = -1;
    int   prev_mode = 0;
    int   tick_cyc[$];

    typedef struct {
        int mode_len;
        int inc_len;
        int inc_off;
        int exp_mode;
        int exp_clr;
        int exp_hi;
        int exp_mi;
    } scen_t;

    scen_t tbl [11];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic raw [2];
        int   old_mode;
        int   new_mode;
        logic phase;
        bit   all_diff;
        logic samp;
        raw[0] = bus.btn_mode_n;
        raw[1] = bus.btn_inc_n;
        if (reset) begin
            m_mode = 0; m_tick = 0; m_clr = 0; m_hi = 0; m_mi = 0; m_bh = 0; m_bm = 0;
            n_run = 0; e_blink = 0;
            for (int b = 0; b < 2; b++) begin
                pipe[b].delete();
                pipe[b].push_back(1'b1);
                pipe[b].push_back(1'b1);
                hist[b].delete();
                lvl[b] = 1'b1;
                ev[b]  = 1'b0;
            end
        end else begin
            old_mode = m_mode;
            new_mode = old_mode;
            m_clr = 0; m_hi = 0; m_mi = 0; m_tick = 0;
            if (ev[0]) begin
                new_mode = (old_mode + 1) % 3;
                m_clr    = (old_mode == 0);
            end else if (ev[1]) begin
                m_hi = (old_mode == 1);
                m_mi = (old_mode == 2);
            end
            if (old_mode == 0 && !ev[0]) begin
                n_run++;
                m_tick = (n_run % CLK_HZ == 0);
            end else begin
                n_run = 0;
            end
            if (new_mode != old_mode || m_hi || m_mi) e_blink = 0;
            else                                      e_blink++;
            phase  = ((e_blink / HALF) % 2) == 1;
            m_bh   = (new_mode == 1) && phase;
            m_bm   = (new_mode == 2) && phase;
            m_mode = new_mode;
            // Button is accepted after DEB consecutive samples differing from the current level.
            for (int b = 0; b < 2; b++) begin
                samp = pipe[b].pop_front();
                pipe[b].push_back(raw[b]);
                hist[b].push_back(samp);
                if (hist[b].size() > DEB) void'(hist[b].pop_front());
                ev[b] = 1'b0;
                if (hist[b].size() == DEB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (hist[b][k] == lvl[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl[b] = samp;
                        hist[b].delete();
                        ev[b] = (samp == 1'b0);
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] got;
        logic [7:0] exp;
        got = {bus.mode, bus.sec_tick, bus.sec_clear, bus.hour_inc, bus.min_inc,
               bus.blank_hour, bus.blank_min};
        exp = {2'(m_mode), m_tick, m_clr, m_hi, m_mi, m_bh, m_bm};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model_compare cycle %0d: got mode/tick/clr/hi/mi/bh/bm=%b expected %b",
                     cyc, got, exp);
        end
        tests++;
        if ($countones({bus.sec_tick, bus.sec_clear, bus.hour_inc, bus.min_inc}) > 1) begin
            fails++;
            $display("FAIL pulse_exclusive cycle %0d: got pulses %b expected at most one high",
                     cyc, {bus.sec_tick, bus.sec_clear, bus.hour_inc, bus.min_inc});
        end
        if (bus.sec_tick)  begin cnt_tick++; tick_cyc.push_back(cyc); end
        if (bus.sec_clear) cnt_clr++;
        if (bus.hour_inc)  cnt_hi++;
        if (bus.min_inc)   cnt_mi++;
        if (prev_mode != 0 && bus.mode == RUN) run_entry = cyc;
        if (bus.sec_tick && run_entry >= 0) begin
            run_gap   = cyc - run_entry;
            run_entry = -1;
        end
        prev_mode = int'(bus.mode);
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bus.btn_mode_n = 1'b1;
        bus.btn_inc_n  = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input int mode_len, input int inc_len, input int inc_off);
        int len;
        len = (mode_len > inc_off + inc_len) ? mode_len : inc_off + inc_len;
        for (int i = 0; i < len; i++) begin
            bus.btn_mode_n = (i < mode_len) ? 1'b0 : 1'b1;
            bus.btn_inc_n  = (i >= inc_off && i < inc_off + inc_len) ? 1'b0 : 1'b1;
            cycle();
        end
        idle(14);
    endtask

    initial begin
        int s_clr, s_hi, s_mi, s_tick, toggles, bh_seen, wait_n, hold_m, hold_i;
        logic last_bm;

        tbl[0]  = '{3,  0,  0, 0, 0, 0, 0};
        tbl[1]  = '{10, 0,  0, 1, 1, 0, 0};
        tbl[2]  = '{0,  10, 0, 1, 0, 1, 0};
        tbl[3]  = '{0,  10, 0, 1, 0, 1, 0};
        tbl[4]  = '{0,  10, 0, 1, 0, 1, 0};
        tbl[5]  = '{10, 0,  0, 2, 0, 0, 0};
        tbl[6]  = '{0,  10, 0, 2, 0, 0, 1};
        tbl[7]  = '{10, 0,  0, 0, 0, 0, 0};
        tbl[8]  = '{10, 0,  0, 1, 1, 0, 0};
        tbl[9]  = '{10, 10, 0, 2, 0, 0, 0};
        tbl[10] = '{10, 0,  0, 0, 0, 0, 0};

        bus.btn_mode_n = 1'b1;
        bus.btn_inc_n  = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_pulses", int'({bus.sec_tick, bus.sec_clear, bus.hour_inc, bus.min_inc}), 0);
        reset = 1'b0;

        // 35 cycles of RUN: three ticks, ten cycles apart
        tick_cyc.delete();
        s_tick = cnt_tick;
        idle(35);
        chk("run_tick_count", cnt_tick - s_tick, 3);
        if (tick_cyc.size() >= 3) begin
            chk("run_tick_spacing_1", tick_cyc[1] - tick_cyc[0], 10);
            chk("run_tick_spacing_2", tick_cyc[2] - tick_cyc[1], 10);
        end
        $display("[TB] run: %0d ticks", cnt_tick - s_tick);

        for (int t = 0; t < 11; t++) begin
            s_clr = cnt_clr; s_hi = cnt_hi; s_mi = cnt_mi;
            press(tbl[t].mode_len, tbl[t].inc_len, tbl[t].inc_off);
            chk($sformatf("scen%0d_mode", t), int'(bus.mode), tbl[t].exp_mode);
            chk($sformatf("scen%0d_sec_clear", t), cnt_clr - s_clr, tbl[t].exp_clr);
            chk($sformatf("scen%0d_hour_inc", t), cnt_hi - s_hi, tbl[t].exp_hi);
            chk($sformatf("scen%0d_min_inc", t), cnt_mi - s_mi, tbl[t].exp_mi);
            $display("[TB] scenario %0d: mode=%0d clr=%0d hi=%0d mi=%0d", t, bus.mode,
                     cnt_clr - s_clr, cnt_hi - s_hi, cnt_mi - s_mi);
        end
        chk("first_tick_after_run", run_gap, 10);

        // SET_MIN idle blinking, then an inc shows the digits immediately
        press(10, 0, 0);
        press(10, 0, 0);
        chk("enter_set_min", int'(bus.mode), 2);
        toggles = 0; bh_seen = 0; last_bm = bus.blank_min;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.blank_min != last_bm) toggles++;
            if (bus.blank_hour) bh_seen++;
            last_bm = bus.blank_min;
        end
        chk("blank_min_toggles", toggles, 4);
        chk("blank_hour_in_set_min", bh_seen, 0);
        bus.btn_inc_n = 1'b0;
        wait_n = 0;
        while (!bus.min_inc && wait_n < 30) begin cycle(); wait_n++; end
        chk("min_inc_seen", int'(bus.min_inc), 1);
        cycle();
        chk("blank_min_after_min_inc", int'(bus.blank_min), 0);
        idle(14);
        $display("[TB] set_min blink: %0d toggles", toggles);

        // Reset mid-SET_MIN while an inc is still debouncing
        s_mi = cnt_mi;
        bus.btn_inc_n = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        reset = 1'b1;
        bus.btn_inc_n = 1'b1;
        cycle();
        chk("reset_mid_debounce_outputs",
            int'({bus.mode, bus.sec_tick, bus.sec_clear, bus.hour_inc, bus.min_inc,
                  bus.blank_hour, bus.blank_min}), 0);
        reset = 1'b0;
        idle(15);
        chk("reset_no_stray_min_inc", cnt_mi - s_mi, 0);
        $display("[TB] reset mid-debounce: mode=%0d", bus.mode);

        // Mode button held through reset release
        bus.btn_mode_n = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0;
        wait_n = 0;
        while (bus.mode != SET_HOUR && wait_n < 30) begin cycle(); wait_n++; end
        chk("held_through_reset_latency", wait_n, DEB + 3);
        idle(14);
        $display("[TB] held through reset: event after %0d cycles", wait_n);

        // Random buttons and occasional reset against the model
        hold_m = 0; hold_i = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_m == 0) begin
                bus.btn_mode_n = 1'($urandom_range(0, 1));
                hold_m = $urandom_range(1, 12);
            end
            if (hold_i == 0) begin
                bus.btn_inc_n = 1'($urandom_range(0, 1));
                hold_i = $urandom_range(1, 12);
            end
            hold_m--; hold_i--;
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        $display("[TB] random: clr=%0d hi=%0d mi=%0d ticks=%0d", cnt_clr, cnt_hi, cnt_mi, cnt_tick);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
